// File: rtl/gpio_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gpio_port_ctrl
// Purpose  : Core-side controller for one GPIO pad wrapper. Drives the pad's
//            A and DIR pins, synchronizes and debounces the pad's Y pin,
//            emits rise/fall event pulses and sequences direction changes
//            so that the input is never trusted before the pad has settled
//            and A is preloaded before the output driver is enabled.
// Ports    : clk       - single clock
//            rst_n     - asynchronous active-low reset (synchronous release)
//            dir_req   - requested direction, 1 = input, 0 = output
//            dout      - data to drive on the pad while in output mode
//            gpio_a    - to GPIO.A
//            gpio_dir  - to GPIO.DIR (1 = input, 0 = output driver enabled)
//            gpio_y    - from GPIO.Y (asynchronous, 0 while output)
//            din       - debounced pad value
//            din_valid - din reflects the settled pad in input mode
//            rise/fall - one-cycle pulses on accepted din edges
//            busy      - direction transition in progress
// Revision : 1.0 - initial release
// ============================================================================
module gpio_port_ctrl #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TURN_CYCLES     = 2,
    parameter int CNT_W           = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic dir_req,
    input  logic dout,
    output logic gpio_a,
    output logic gpio_dir,
    input  logic gpio_y,
    output logic din,
    output logic din_valid,
    output logic rise,
    output logic fall,
    output logic busy
);

    // State encoding
    localparam logic [1:0] c_st_settle  = 2'd0;
    localparam logic [1:0] c_st_in      = 2'd1;
    localparam logic [1:0] c_st_pre_out = 2'd2;
    localparam logic [1:0] c_st_out     = 2'd3;

    // Counter end points: compared against the value held before the edge,
    // so SETTLE spans SYNC_STAGES+TURN_CYCLES edges and a change is accepted
    // on the DEBOUNCE_CYCLES-th consecutive differing sample.
    localparam logic [CNT_W-1:0] c_settle_last = CNT_W'(SYNC_STAGES + TURN_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_deb_last    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_zero    = '0;
    localparam logic [CNT_W-1:0] c_cnt_one     = CNT_W'(1);

    logic [1:0]             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_gpio_a;
    logic                   r_gpio_dir;
    logic                   r_din;
    logic                   r_din_valid;
    logic                   r_rise;
    logic                   r_fall;
    logic                   r_busy;

    logic [1:0]             w_state_nxt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   w_gpio_a_nxt;
    logic                   w_din_nxt;
    logic                   w_rise_nxt;
    logic                   w_fall_nxt;
    logic                   w_sync;

    assign w_sync = r_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_din_nxt    = r_din;
        w_rise_nxt   = 1'b0;
        w_fall_nxt   = 1'b0;
        w_gpio_a_nxt = r_gpio_a;

        case (r_state)
            c_st_settle: begin
                if (!dir_req) begin
                    w_state_nxt = c_st_pre_out;
                    w_cnt_nxt   = c_cnt_zero;
                end else if (r_cnt == c_settle_last) begin
                    // Pad has settled: adopt its value silently.
                    w_din_nxt   = w_sync;
                    w_cnt_nxt   = c_cnt_zero;
                    w_state_nxt = c_st_in;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end

            c_st_in: begin
                if (!dir_req) begin
                    // Any pending debounce is dropped without a pulse.
                    w_state_nxt = c_st_pre_out;
                    w_cnt_nxt   = c_cnt_zero;
                end else if (w_sync == r_din) begin
                    w_cnt_nxt = c_cnt_zero;
                end else if (r_cnt == c_deb_last) begin
                    w_din_nxt  = w_sync;
                    w_rise_nxt = w_sync;
                    w_fall_nxt = ~w_sync;
                    w_cnt_nxt  = c_cnt_zero;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end

            c_st_pre_out: begin
                if (!dir_req) begin
                    w_state_nxt = c_st_out;
                end else begin
                    w_state_nxt = c_st_settle;
                    w_cnt_nxt   = c_cnt_zero;
                end
            end

            c_st_out: begin
                if (dir_req) begin
                    w_state_nxt = c_st_settle;
                    w_cnt_nxt   = c_cnt_zero;
                end
            end

            default: begin
                w_state_nxt = c_st_settle;
                w_cnt_nxt   = c_cnt_zero;
            end
        endcase

        // A follows dout on every edge that lands in PRE_OUT or OUT, which
        // preloads it one cycle before the driver is enabled. Leaving OUT
        // keeps the last driven value.
        if ((w_state_nxt == c_st_pre_out) || (w_state_nxt == c_st_out)) begin
            w_gpio_a_nxt = dout;
        end
    end

    // ------------------------------------------------------------------------
    // State, counter, synchronizer and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_st_settle;
            r_cnt       <= c_cnt_zero;
            r_sync      <= '0;
            r_gpio_a    <= 1'b0;
            r_gpio_dir  <= 1'b1;
            r_din       <= 1'b0;
            r_din_valid <= 1'b0;
            r_rise      <= 1'b0;
            r_fall      <= 1'b0;
            r_busy      <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_sync      <= {r_sync[SYNC_STAGES-2:0], gpio_y};
            r_gpio_a    <= w_gpio_a_nxt;
            r_gpio_dir  <= (w_state_nxt != c_st_out);
            r_din       <= w_din_nxt;
            r_din_valid <= (w_state_nxt == c_st_in);
            r_rise      <= w_rise_nxt;
            r_fall      <= w_fall_nxt;
            r_busy      <= (w_state_nxt == c_st_settle) || (w_state_nxt == c_st_pre_out);
        end
    end

    assign gpio_a    = r_gpio_a;
    assign gpio_dir  = r_gpio_dir;
    assign din       = r_din;
    assign din_valid = r_din_valid;
    assign rise      = r_rise;
    assign fall      = r_fall;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_gpio_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpio_port_ctrl
// Purpose  : Self-checking bench for gpio_port_ctrl: directed scenarios plus
//            randomized traffic, compared every cycle against a behavioural
//            model of the pad controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_port_ctrl;

    localparam int SYNC_STAGES     = 2;
    localparam int DEBOUNCE_CYCLES = 4;
    localparam int TURN_CYCLES     = 2;
    localparam int CNT_W           = 8;

    logic clk;
    logic rst_n;
    logic dir_req;
    logic dout;
    logic gpio_a;
    logic gpio_dir;
    logic gpio_y;
    logic din;
    logic din_valid;
    logic rise;
    logic fall;
    logic busy;

    gpio_port_ctrl #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .TURN_CYCLES    (TURN_CYCLES),
        .CNT_W          (CNT_W)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .dir_req  (dir_req),
        .dout     (dout),
        .gpio_a   (gpio_a),
        .gpio_dir (gpio_dir),
        .gpio_y   (gpio_y),
        .din      (din),
        .din_valid(din_valid),
        .rise     (rise),
        .fall     (fall),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model: pad mode, a delay line of raw samples standing in for
    // the synchronizer, the number of edges spent settling and the length of
    // the current run of samples that disagree with din.
    // ------------------------------------------------------------------------
    localparam int MODE_SETTLE = 0;
    localparam int MODE_LISTEN = 1;
    localparam int MODE_PRELOAD = 2;
    localparam int MODE_DRIVE  = 3;

    int   m_mode;
    int   m_settled;
    int   m_run;
    bit   m_samples[$];
    bit   m_a, m_din, m_rise, m_fall;

    task automatic model_reset();
        m_mode    = MODE_SETTLE;
        m_settled = 0;
        m_run     = 0;
        m_samples.delete();
        for (int i = 0; i < SYNC_STAGES; i++) m_samples.push_back(1'b0);
        m_a    = 1'b0;
        m_din  = 1'b0;
        m_rise = 1'b0;
        m_fall = 1'b0;
    endtask

    task automatic model_step();
        bit seen;
        seen   = m_samples[0];
        m_rise = 1'b0;
        m_fall = 1'b0;
        case (m_mode)
            MODE_SETTLE: begin
                if (!dir_req) begin
                    m_mode = MODE_PRELOAD;
                    m_a    = dout;
                end else begin
                    m_settled++;
                    if (m_settled == SYNC_STAGES + TURN_CYCLES) begin
                        m_din  = seen;
                        m_run  = 0;
                        m_mode = MODE_LISTEN;
                    end
                end
            end
            MODE_LISTEN: begin
                if (!dir_req) begin
                    m_mode = MODE_PRELOAD;
                    m_a    = dout;
                    m_run  = 0;
                end else if (seen != m_din) begin
                    m_run++;
                    if (m_run == DEBOUNCE_CYCLES) begin
                        m_din  = seen;
                        m_rise = seen;
                        m_fall = !seen;
                        m_run  = 0;
                    end
                end else begin
                    m_run = 0;
                end
            end
            MODE_PRELOAD: begin
                if (!dir_req) begin
                    m_mode = MODE_DRIVE;
                    m_a    = dout;
                end else begin
                    m_mode    = MODE_SETTLE;
                    m_settled = 0;
                end
            end
            default: begin
                if (dir_req) begin
                    m_mode    = MODE_SETTLE;
                    m_settled = 0;
                end else begin
                    m_a = dout;
                end
            end
        endcase
        void'(m_samples.pop_front());
        m_samples.push_back(gpio_y);
    endtask

    task automatic check_all();
        chk("gpio_a",    gpio_a,    m_a);
        chk("gpio_dir",  gpio_dir,  m_mode != MODE_DRIVE);
        chk("din",       din,       m_din);
        chk("din_valid", din_valid, m_mode == MODE_LISTEN);
        chk("rise",      rise,      m_rise);
        chk("fall",      fall,      m_fall);
        chk("busy",      busy,      (m_mode == MODE_SETTLE) || (m_mode == MODE_PRELOAD));
        chk("rise_and_fall", rise & fall, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_step();
        #1;
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Assert reset between edges and check that outputs drop at once.
    task automatic async_reset_pulse();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        ticks(2);
        rst_n = 1'b1;
    endtask

    int rise_cnt;
    int fall_cnt;

    initial begin
        rst_n   = 1'b0;
        dir_req = 1'b1;
        dout    = 1'b0;
        gpio_y  = 1'b1;
        model_reset();
        ticks(2);
        rst_n = 1'b1;

        // Power-up settle: input trusted only after the fourth edge.
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("settle_valid", din_valid, i >= 4);
        end
        chk("settle_din", din, 1'b1);

        // Bring din to 0, then a 2-sample glitch must be rejected.
        gpio_y = 1'b0;
        ticks(8);
        gpio_y = 1'b1;
        ticks(2);
        gpio_y = 1'b0;
        rise_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            rise_cnt += int'(rise);
        end
        chk("glitch_pulses", rise_cnt, 0);
        chk("glitch_din", din, 1'b0);

        // Stable high: din and rise exactly six edges after the change.
        gpio_y = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("rise_latency", rise, i == 6);
        end
        gpio_y = 1'b0;
        fall_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            fall_cnt += int'(fall);
        end
        chk("fall_once", fall_cnt, 1);

        // Turn to output with A preloaded, then dout toggling.
        dout    = 1'b1;
        dir_req = 1'b0;
        tick();
        chk("preload_a", gpio_a, 1'b1);
        chk("preload_dir", gpio_dir, 1'b1);
        tick();
        chk("out_dir", gpio_dir, 1'b0);
        dout = 1'b0; tick();
        dout = 1'b1; tick();
        dout = 1'b0; tick();
        chk("out_follow", gpio_a, 1'b0);

        // Back to input with pad reading high; captured silently.
        gpio_y  = 1'b1;
        dir_req = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("turn_valid", din_valid, i >= 5);
        end

        // One-cycle dir_req low pulse: PRE_OUT then SETTLE, driver never on.
        dout    = 1'b0;
        dir_req = 1'b0;
        tick();
        dir_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("pulse_dir", gpio_dir, 1'b1);
        end
        chk("pulse_a", gpio_a, 1'b0);

        // Reset mid-debounce (counter reaches 2 after four edges).
        gpio_y = 1'b0;
        ticks(4);
        async_reset_pulse();
        gpio_y = 1'b1;
        ticks(6);

        // Reset while driving the pad.
        dout    = 1'b1;
        dir_req = 1'b0;
        ticks(4);
        async_reset_pulse();
        dir_req = 1'b1;
        ticks(6);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(15) == 0) dir_req = ~dir_req;
            if ($urandom_range(2) == 0)  dout    = 1'($urandom);
            if ($urandom_range(4) == 0)  gpio_y  = ~gpio_y;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
